// File: rtl/aes256_key_unexpand.sv
// Inverse AES-256 key schedule: walks round keys 14 down to 0 from w52..w59.
// Optional AES256_KEYUNEXP_ZEROIZE_EN clears key material when done pulses.
module aes256_key_unexpand (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         key_valid,
  input  logic         key_ready,
  output logic [127:0] out_key,
  output logic [3:0]   round_idx,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE,
    EMIT_HI,
    EMIT_LO,
    DONE
  } state_t;

  state_t         state;
  logic [255:0]   window;
  logic           accept;

  logic [31:0]    w3;
  logic [31:0]    w4;
  logic [31:0]    w5;
  logic [31:0]    w6;
  logic [31:0]    w7;
  logic           odd_k;
  logic [31:0]    sel;
  logic [31:0]    sub;
  logic [7:0]     rcon;
  logic [31:0]    f;
  logic [127:0]   new4;

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8); 0 maps to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b
         ^ {b[6:0], b[7]}
         ^ {b[5:0], b[7:6]}
         ^ {b[4:0], b[7:5]}
         ^ {b[3:0], b[7:4]}
         ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]),
            sbox(x[15:8]),  sbox(x[7:0])};
  endfunction

  assign accept = key_valid & key_ready;

  // window = {w[4k] .. w[4k+7]}, w[4k] in the top word
  assign w3 = window[159:128];
  assign w4 = window[127:96];
  assign w5 = window[95:64];
  assign w6 = window[63:32];
  assign w7 = window[31:0];

  // in EMIT_LO round_idx is k; odd k means j=4k+4 is a multiple of 8
  assign odd_k = round_idx[0];
  assign sel   = odd_k ? {w3[23:0], w3[31:24]} : w3;
  assign sub   = sub_word(sel);
  assign rcon  = 8'h01 << round_idx[3:1];
  assign f     = sub ^ (odd_k ? {rcon, 24'h000000} : 32'h0);

  // all four words come from the old window, no chaining inside a step
  assign new4 = {w4 ^ f, w5 ^ w4, w6 ^ w5, w7 ^ w6};

  // control FSM with registered outputs and the key window
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      window    <= '0;
      out_key   <= '0;
      round_idx <= '0;
      busy      <= 1'b0;
      key_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            window    <= key_in;
            out_key   <= key_in[127:0];
            round_idx <= 4'd14;
            key_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= EMIT_HI;
          end
        end
        EMIT_HI: begin
          if (accept) begin
            out_key   <= window[255:128];
            round_idx <= round_idx - 4'd1;
            state     <= EMIT_LO;
          end
        end
        EMIT_LO: begin
          if (accept) begin
            if (round_idx == 4'd0) begin
              key_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
`ifdef AES256_KEYUNEXP_ZEROIZE_EN
              window    <= '0;
              out_key   <= '0;
`endif
              state     <= DONE;
            end else begin
              window    <= {new4, window[255:128]};
              out_key   <= new4;
              round_idx <= round_idx - 4'd1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/aes256_key_unexpand.md
Name: aes256_key_unexpand

Overview:
Inverse AES-256 key schedule. It is loaded with the last two round keys (w[52..59]) and walks the schedule backwards. It emits round keys 14, 13, …, 0 one per accepted beat on a valid/ready stream. It is the reverse-order counterpart of the forward key expansion. It feeds inverse-cipher round logic and also lets the forward key be recovered from the final key material.

Parameters:
None; the key size is fixed at 256 bits and there are 15 round keys.

Ports:
clk        input   1    rising-edge clock
rst        input   1    synchronous, active-high reset
start      input   1    load key_in and begin; honoured only when busy=0
key_in     input   256  {w52,w53,...,w59}; w52 in bits [255:224]
busy       output  1    high from the accepted start until the last beat is accepted
key_valid  output  1    out_key/round_idx hold a valid round key
key_ready  input   1    consumer accepts the beat when key_valid & key_ready
out_key    output  128  round key {w[4r],w[4r+1],w[4r+2],w[4r+3]}
round_idx  output  4    r of the current out_key, 14 down to 0
done       output  1    one-cycle pulse in the cycle after round 0 is accepted

Behaviour:
- Reset (rst=1 at a clock edge):
  - busy=0, key_valid=0, done=0.
  - out_key=0, round_idx=0.
  - 256-bit window register cleared.
  - rst has priority over every other input, including mid-sequence; the sequence is abandoned with no done pulse.
- State machine: IDLE, EMIT_HI, EMIT_LO, DONE.
- IDLE:
  - start=1 → window<=key_in, out_key<=w56..w59, round_idx<=14, key_valid<=1, busy<=1; go to EMIT_HI.
  - First beat is visible one cycle after start.
- EMIT_HI (window = w[4k..4k+7], out_key = upper half, r=k+1):
  - On accept: out_key<=lower half w[4k..4k+3], round_idx<=k; go to EMIT_LO.
- EMIT_LO (out_key = w[4k..4k+3], r=k):
  - On accept with k=0: key_valid<=0, busy<=0, done<=1; go to DONE.
  - On accept with k>0: compute new words w[4k-4..4k-1] combinationally in one cycle.
    - Window <= {new4, w[4k..4k+3]}.
    - out_key<=new4, round_idx<=k-1; stay in EMIT_LO.
- DONE: done<=0; go to IDLE next cycle.
- Backward step, per word, for j = 4k+4 .. 4k+7: w[j-8] = w[j] ^ f(w[j-1]), with j-1 taken from the old window (no intra-step chaining).
  - f = identity except at j=4k+4.
  - At j=4k+4: if j mod 8 = 0, f = SubWord(RotWord(x)) ^ {Rcon[j/8],24'h0}; if j mod 8 = 4, f = SubWord(x).
  - Rcon[1..7] = 01,02,04,08,10,20,40.
  - One 4-byte S-box instance is sufficient.
- Stall: while key_valid=1 and key_ready=0, out_key, round_idx and the window hold unchanged.
- Beat count: exactly 15 accepted beats per start, round_idx strictly decreasing 14→0.
- Minimum latency: start to done is 16 cycles with key_ready tied high.
- start while busy=1 is ignored; there is no restart.
- start in the DONE cycle is ignored.
- start and key_ready both high in IDLE: key_ready has no effect.

Optional Feature:
AES256_KEYUNEXP_ZEROIZE_EN
- Defined: in the cycle done pulses, the window register and out_key are cleared to 0.
  - Key material is not left resident after use.
  - round_idx reads 0.
- Undefined: after done, out_key holds round key 0 and the window holds w0..w7 until the next start or rst.

Test Plan:
- FIPS-197 C.3 final key, key_in = 4e5a6699a9f24fe07e572baacdf8cdea_24fc79ccbf0979e9371ac23c6d68de36, key_ready=1:
  - beat 0 = 24fc79ccbf0979e9371ac23c6d68de36, r=14;
  - beat 1 = 4e5a6699a9f24fe07e572baacdf8cdea, r=13;
  - beat 13 = 101112131415161718191a1b1c1d1e1f, r=1;
  - beat 14 = 000102030405060708090a0b0c0d0e0f, r=0;
  - done pulses 16 cycles after start.
- Same vector with key_ready random at ~50%: identical 15-beat sequence, no dropped or duplicated beats, outputs stable during stalls.
- Assert rst at beat r=7: next cycle busy=0, key_valid=0, out_key=0, no done pulse. A fresh start then yields the full 14→0 sequence.
- Pulse start again at beat r=10: ignored; the sequence continues unchanged to r=0.
- Round-trip: run the forward key expansion on key 642423baa95efb4362d3f2ce993c0904150f258aa1fe796841d7b4429c9b5a30 and feed its rounds 13|14 into this block. Every reversed beat matches the forward round key of the same index; round 0|1 equals the original key.
- Build with AES256_KEYUNEXP_ZEROIZE_EN: after done, out_key=0 and an internal window probe reads 0. Without the macro, out_key reads 000102…0f after the C.3 run.
